alu_mp_seq: RTL
===============

Name: alu_mp_seq

Overview:
Multi-precision arithmetic sequencer for the 8-bit ALU datapath (alu_8b).
- Accepts add, sub and neg commands on NBYTES-wide operands.
- Drives the combinational 8-bit ALU one byte per cycle, LSB first, chaining carry/borrow between bytes.
- Returns the assembled result with N/Z/V/C flags through a start/busy/done handshake.
- Sits between the CPU control logic and a single alu_8b instance; it owns that ALU's select, ci and operand inputs.

Parameters:
NBYTES, 4, number of 8-bit slices per operand (operand width W = 8*NBYTES); legal range 2..8.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  command request; sampled only in IDLE
op  input  2  2'b01 add, 2'b10 sub, 2'b11 neg (0 - b), 2'b00 clear
cin  input  1  carry/borrow into byte 0
a  input  W  operand A; captured on accepted start
b  input  W  operand B; captured on accepted start
busy  output  1  high while a command is in progress
done  output  1  one-cycle pulse when result and flags are valid
result  output  W  registered result; holds until next accepted start
flags  output  4  {N,Z,V,C}; registered, holds with result
alu_select  output  4  to ALU select
alu_ci  output  1  to ALU ci
alu_a  output  8  to ALU a0
alu_b  output  8  to ALU b0
alu_y  input  8  from ALU y
alu_co  input  1  from ALU co

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, busy=0, done=0, result=0, flags=4'b0000, byte index=0.
  - alu_select=0, alu_ci=0, alu_a=0, alu_b=0.
  - Reset during RUN abandons the command; no done pulse is produced.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - alu_select=0.
  - start=1 latches a, b, op and cin into internal registers, clears the accumulated Z to 1 and sets index=0, then moves to RUN.
  - busy=1 from the next cycle.
- RUN, one byte per cycle:
  - alu_select = {2'b00, op_reg}.
  - alu_a = a_reg byte[index], alu_b = b_reg byte[index].
  - alu_ci = cin_reg at index 0, otherwise the carry saved from the previous byte.
  - At the clk edge: result byte[index] <= alu_y, carry <= alu_co, Zacc <= Zacc & ~|alu_y, index <= index+1.
  - At index = NBYTES-1 the state moves to DONE and flags are registered:
    - N = alu_y[7].
    - Z = final Zacc.
    - C = alu_co (carry for add, borrow for sub/neg).
    - V for add = (a7==b7) & (y7!=a7).
    - V for sub and neg = (a7!=b7) & (y7!=a7), where a7 is taken as 0 for neg.
    - a7 and b7 are the MSBs of the top byte; y7 is alu_y[7] of the top byte.
- DONE:
  - done=1 for exactly one cycle, busy=0, then the state returns to IDLE.
  - A start asserted in DONE is ignored; only IDLE accepts start.
- Latency: start accepted at edge k gives busy=1 for edges k+1..k+NBYTES and done=1 in the cycle after edge k+NBYTES. Total is NBYTES+1 cycles per command; no pipelining.
- start while busy is ignored; input changes during RUN have no effect.
- op=2'b00: the ALU returns y=0 and co=0 for every byte, so result=0 and flags=4'b0100.
- result and flags are stable from the done pulse until the first RUN edge of the next accepted command.
- Internal byte registers update in place during RUN; the result output must not be observed as valid while busy=1.

Test Plan:
- NBYTES=4, add a=32'h0000FFFF, b=32'h00000001, cin=0 -> result 32'h00010000, flags N0 Z0 V0 C0. done pulses exactly 5 cycles after the start edge, with busy high for 4 cycles.
- sub a=0, b=1, cin=0 -> result 32'hFFFFFFFF, flags N1 Z0 V0 C1.
- add a=32'h7FFFFFFF, b=1 -> result 32'h80000000, N1 Z0 V1 C0. Then add a=32'hFFFFFFFF, b=1 -> result 0, N0 Z1 V0 C1.
- neg b=32'h80000000 -> result 32'h80000000, V1 N1 C1. Then neg b=5 -> result 32'hFFFFFFFB, N1 V0 C1.
- Assert start with new operands on every cycle during RUN and DONE -> they are ignored and the first command completes unchanged. Then pulse rst at index 2 -> the next cycle shows busy=0, done=0, result=0, flags=0, with no done pulse.
- Cycle-by-cycle probe of the ALU side during add a=32'h01FF01FF, b=32'h00010001 -> the alu_ci sequence is 0,1,0,1 and alu_a/alu_b step through the bytes LSB first. Final result is 32'h02000200.

Source files
------------

// File: rtl/alu_mp_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_mp_seq
// Description : Multi-precision add/sub/neg sequencer. It drives a single
//               combinational 8-bit ALU one byte per cycle, LSB first, and
//               chains carry/borrow between bytes. It returns the assembled
//               result and {N,Z,V,C} flags through a start/busy/done
//               handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            system clock
//   rst            synchronous, active-high reset
//   i_start        command request, sampled only in IDLE
//   i_op           01 add, 10 sub, 11 neg (0 - b), 00 clear
//   i_cin          carry/borrow into byte 0
//   i_a, i_b       operands, captured on an accepted start
//   o_busy         high while a command is in progress
//   o_done         one-cycle pulse when o_result/o_flags are valid
//   o_result       registered result
//   o_flags        registered {N,Z,V,C}
//   o_alu_select   ALU select
//   o_alu_ci       ALU carry in
//   o_alu_a/b      ALU byte operands
//   i_alu_y        ALU byte result
//   i_alu_co       ALU carry/borrow out
// ============================================================================
module alu_mp_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [1:0]            i_op,
  input  logic                  i_cin,
  input  logic [8*NBYTES-1:0]   i_a,
  input  logic [8*NBYTES-1:0]   i_b,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [8*NBYTES-1:0]   o_result,
  output logic [3:0]            o_flags,
  output logic [3:0]            o_alu_select,
  output logic                  o_alu_ci,
  output logic [7:0]            o_alu_a,
  output logic [7:0]            o_alu_b,
  input  logic [7:0]            i_alu_y,
  input  logic                  i_alu_co
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] c_LAST = IW'(NBYTES - 1);

  localparam logic [1:0] c_OP_CLR = 2'b00;
  localparam logic [1:0] c_OP_ADD = 2'b01;
  localparam logic [1:0] c_OP_SUB = 2'b10;
  localparam logic [1:0] c_OP_NEG = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [1:0]      r_op;
  logic            r_cin;
  logic            r_carry;
  logic            r_zacc;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_result;
  logic [3:0]      r_flags;

  logic            w_accept;
  logic            w_last;
  logic [7:0]      w_a_byte;
  logic [7:0]      w_b_byte;
  logic            w_a7;
  logic            w_b7;
  logic            w_y7;
  logic            w_v;
  logic            w_zfinal;

  assign w_accept = (r_state == S_IDLE) && i_start;
  assign w_last   = (r_idx == c_LAST);
  assign w_a_byte = r_a[{r_idx, 3'b000} +: 8];
  assign w_b_byte = r_b[{r_idx, 3'b000} +: 8];

  // Overflow uses the operand MSBs of the top byte; neg behaves as 0 - b.
  assign w_a7     = (r_op == c_OP_NEG) ? 1'b0 : r_a[W-1];
  assign w_b7     = r_b[W-1];
  assign w_y7     = i_alu_y[7];
  assign w_zfinal = r_zacc & ~|i_alu_y;

  always_comb begin
    w_v = 1'b0;
    case (r_op)
      c_OP_ADD: w_v = (w_a7 == w_b7) && (w_y7 != w_a7);
      c_OP_SUB,
      c_OP_NEG: w_v = (w_a7 != w_b7) && (w_y7 != w_a7);
      default:  w_v = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_alu_select = 4'b0000;
    o_alu_ci     = 1'b0;
    o_alu_a      = 8'h00;
    o_alu_b      = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        o_busy       = 1'b1;
        o_alu_select = {2'b00, r_op};
        o_alu_a      = w_a_byte;
        o_alu_b      = w_b_byte;
        // Byte 0 takes the command carry; later bytes chain the saved one.
        o_alu_ci     = (r_idx == '0) ? r_cin : r_carry;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= c_OP_CLR;
      r_cin    <= 1'b0;
      r_carry  <= 1'b0;
      r_zacc   <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_flags  <= 4'b0000;
    end else if (w_accept) begin
      r_a    <= i_a;
      r_b    <= i_b;
      r_op   <= i_op;
      r_cin  <= i_cin;
      r_zacc <= 1'b1;
      r_idx  <= '0;
    end else if (r_state == S_RUN) begin
      // Result bytes are overwritten in place; o_result is only meaningful
      // once busy drops.
      r_result[{r_idx, 3'b000} +: 8] <= i_alu_y;
      r_carry <= i_alu_co;
      r_zacc  <= w_zfinal;
      r_idx   <= r_idx + 1'b1;
      if (w_last) begin
        r_flags <= {w_y7, w_zfinal, w_v, i_alu_co};
      end
    end
  end

  assign o_result = r_result;
  assign o_flags  = r_flags;

endmodule
`default_nettype wire
